spio_ledarb: RTL and testbench

Round-robin LED ownership scheduler in front of the special-purpose I/O register. It shares the register's LED byte among NREQ requesters (CPU shadow, debug bus, status engines). Each granted owner keeps its pattern on the LEDs for at least MIN_HOLD cycles. Updates are issued as Wishbone masked writes (sel = 4'b0011) that never touch the demo-mode bit. Sits between the requesters and the spio slave port in the peripheral bus mux.

---
 rtl/spio_ledarb_pkg.sv | 13 +
 rtl/spio_ledarb_if.sv | 15 +
 rtl/spio_ledarb_rrpick.sv | 30 +++
 rtl/spio_ledarb.sv | 197 +++++++++++++++++++
 tb/tb_spio_ledarb.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/spio_ledarb_pkg.sv
// spio_pkg: arbiter states and Wishbone constants shared by the spio LED arbiter files.
package spio_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_OWN   = 2'd2
   } spio_state_e;

   localparam logic [3:0] SPIO_LED_SEL  = 4'b0011;
   localparam logic [3:0] SPIO_WD_LIMIT = 4'd15;

endpackage

// File: rtl/spio_ledarb_if.sv
// spio_ledarb_if: Wishbone write path between the LED arbiter (master) and the spio slave port.
interface spio_ledarb_if;

   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] data;
   logic [3:0]  sel;
   logic        stall;
   logic        ack;

   modport master (output cyc, stb, we, data, sel, input stall, ack);
   modport slave  (input cyc, stb, we, data, sel, output stall, ack);

endinterface

// File: rtl/spio_ledarb_rrpick.sv
// spio_rrpick: combinational round-robin picker; the first request strictly after ptr wins (wrapping).
module spio_rrpick
   import spio_pkg::*;
#(
   parameter int  NREQ = 4,
   localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic            valid
);

   logic [PW-1:0] idx;

   // The pointer itself is visited last, so the previous winner has lowest priority.
   always_comb begin
      gnt   = '0;
      valid = 1'b0;
      idx   = '0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = PW'((int'(ptr) + i) % NREQ);
         if (!valid && req[idx]) begin
            gnt[idx] = 1'b1;
            valid    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/spio_ledarb.sv
// spio_ledarb: round-robin LED ownership scheduler issuing masked Wishbone writes to spio.
// Define SPIO_LEDARB_TIMEOUT_EN to add a bus watchdog that aborts and retries stuck writes.
module spio_ledarb
   import spio_pkg::*;
#(
   parameter int               NREQ     = 4,
   parameter int               NLEDS    = 8,
   parameter int               HOLDW    = 24,
   parameter logic [HOLDW-1:0] MIN_HOLD = 24'd100000
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic [NREQ-1:0]       i_req,
   input  logic [NREQ*NLEDS-1:0] i_led,
   input  logic [NREQ-1:0]       i_upd,
   output logic [NREQ-1:0]       o_gnt,
   spio_ledarb_if.master         wb,
   output logic                  o_busy,
   output logic                  o_err
);

   localparam int         PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [7:0] LED_MASK = 8'((9'd1 << NLEDS) - 9'd1);

   spio_state_e      state_q, state_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [HOLDW-1:0] hold_q, hold_d, hold_inc;
   logic             pend_q, pend_d;
   logic             cyc_q, cyc_d, stb_q, stb_d;
   logic [31:0]      data_q, data_d;
   logic [NREQ-1:0]  pick_gnt;
   logic             pick_any;
   logic [PW-1:0]    win_idx;
   logic [7:0]       win_pat, own_pat;
   logic             held, owner_req, owner_upd;
`ifdef SPIO_LEDARB_TIMEOUT_EN
   logic [3:0]       wd_q, wd_d;
   logic             err_q, err_d;
`endif

   // The current owner is masked out so a pick in OWN always means a different requester.
   spio_rrpick #(.NREQ(NREQ)) u_pick (
      .req   (i_req & ~gnt_q),
      .ptr   (ptr_q),
      .gnt   (pick_gnt),
      .valid (pick_any)
   );

   assign hold_inc  = (&hold_q) ? hold_q : hold_q + 1'b1;
   assign held      = (hold_q >= MIN_HOLD);
   assign owner_req = |(i_req & gnt_q);
   assign owner_upd = |(i_upd & gnt_q);

   always_comb begin
      win_idx = '0;
      for (int k = 0; k < NREQ; k++)
         if (pick_gnt[k]) win_idx = PW'(k);
      win_pat = '0;
      own_pat = '0;
      win_pat[NLEDS-1:0] = i_led[int'(win_idx)*NLEDS +: NLEDS];
      own_pat[NLEDS-1:0] = i_led[int'(ptr_q)*NLEDS +: NLEDS];
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      pend_d  = pend_q;
      cyc_d   = cyc_q;
      stb_d   = stb_q;
      data_d  = data_q;
`ifdef SPIO_LEDARB_TIMEOUT_EN
      wd_d    = wd_q;
      err_d   = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               gnt_d   = pick_gnt;
               ptr_d   = win_idx;
               data_d  = {16'h0, LED_MASK, win_pat};
               hold_d  = '0;
               pend_d  = 1'b0;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               state_d = ST_WRITE;
`ifdef SPIO_LEDARB_TIMEOUT_EN
               wd_d    = '0;
`endif
            end
         end
         ST_WRITE: begin
            hold_d = hold_inc;
            if (owner_upd) pend_d = 1'b1;
            if (stb_q && !wb.stall) stb_d = 1'b0;
            if (wb.ack) begin
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
               state_d = ST_OWN;
            end
`ifdef SPIO_LEDARB_TIMEOUT_EN
            else if (wd_q == SPIO_WD_LIMIT - 4'd1) begin
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
               err_d   = 1'b1;
               pend_d  = 1'b1;
               state_d = ST_OWN;
            end else begin
               wd_d = wd_q + 4'd1;
            end
`endif
         end
         ST_OWN: begin
            // Release and preemption only once the ownership window has elapsed.
            if (held && (pick_any || !owner_req)) begin
               if (pick_any) begin
                  gnt_d   = pick_gnt;
                  ptr_d   = win_idx;
                  data_d  = {16'h0, LED_MASK, win_pat};
                  hold_d  = '0;
                  pend_d  = 1'b0;
                  cyc_d   = 1'b1;
                  stb_d   = 1'b1;
                  state_d = ST_WRITE;
`ifdef SPIO_LEDARB_TIMEOUT_EN
                  wd_d    = '0;
`endif
               end else begin
                  gnt_d   = '0;
                  hold_d  = '0;
                  pend_d  = 1'b0;
                  state_d = ST_IDLE;
               end
            end else if (owner_upd || pend_q) begin
               data_d  = {16'h0, LED_MASK, own_pat};
               pend_d  = 1'b0;
               hold_d  = hold_inc;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               state_d = ST_WRITE;
`ifdef SPIO_LEDARB_TIMEOUT_EN
               wd_d    = '0;
`endif
            end else begin
               hold_d = hold_inc;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         ptr_q   <= PW'(NREQ - 1);
         hold_q  <= '0;
         pend_q  <= 1'b0;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
         data_q  <= '0;
`ifdef SPIO_LEDARB_TIMEOUT_EN
         wd_q    <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         pend_q  <= pend_d;
         cyc_q   <= cyc_d;
         stb_q   <= stb_d;
         data_q  <= data_d;
`ifdef SPIO_LEDARB_TIMEOUT_EN
         wd_q    <= wd_d;
         err_q   <= err_d;
`endif
      end
   end

   assign o_gnt   = gnt_q;
   assign wb.cyc  = cyc_q;
   assign wb.stb  = stb_q;
   assign wb.we   = cyc_q;
   assign wb.data = data_q;
   assign wb.sel  = cyc_q ? SPIO_LED_SEL : 4'b0000;
   assign o_busy  = (state_q == ST_WRITE);
`ifdef SPIO_LEDARB_TIMEOUT_EN
   assign o_err   = err_q;
`else
   assign o_err   = 1'b0;
`endif

endmodule

// File: tb/tb_spio_ledarb.sv
// tb_spio_ledarb: directed bench for spio_ledarb (MIN_HOLD=16) against a simple spio slave model.
module tb_spio_ledarb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req, upd, gnt;
   logic [31:0] led;
   logic        busy, err;
   logic        ack_enable;
   logic [31:0] last_wdata = '0;
   logic [7:0]  led_reg, led_pin;
   int          wr_count   = 0;
   int          twohot_cnt = 0;
   int          err_cnt    = 0;
   int          errors     = 0;
   int          checks     = 0;

   spio_ledarb_if wb ();

   spio_ledarb #(
      .NREQ     (4),
      .NLEDS    (8),
      .HOLDW    (24),
      .MIN_HOLD (24'd16)
   ) dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .i_req     (req),
      .i_led     (led),
      .i_upd     (upd),
      .o_gnt     (gnt),
      .wb        (wb),
      .o_busy    (busy),
      .o_err     (err)
   );

   always #5 clk = ~clk;

   // spio slave: accept when stb && !stall, ack next cycle, latch LEDs on ack, drive pins one cycle later.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb.ack  <= 1'b0;
         led_reg <= 8'h00;
         led_pin <= 8'h00;
      end else begin
         wb.ack <= 1'b0;
         if (wb.cyc && wb.stb && !wb.stall) begin
            wr_count   <= wr_count + 1;
            last_wdata <= wb.data;
            if (ack_enable) wb.ack <= 1'b1;
         end
         if (wb.ack) led_reg <= (led_reg & ~last_wdata[15:8]) | (last_wdata[7:0] & last_wdata[15:8]);
         led_pin <= led_reg;
      end
   end

   always @(negedge clk) begin
      if ($countones(gnt) > 1) twohot_cnt++;
      if (err) err_cnt++;
   end

   task automatic test_reset();
      rst_n = 1'b0; req = '0; upd = '0; led = '0; wb.stall = 1'b0; ack_enable = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (gnt !== 4'h0) begin errors++; $display("[TB] FAIL reset_gnt: got %h expected %h", gnt, 4'h0); end
      checks++; if (wb.cyc !== 1'b0 || wb.stb !== 1'b0 || wb.we !== 1'b0) begin errors++; $display("[TB] FAIL reset_bus: got cyc=%b stb=%b we=%b expected 0 0 0", wb.cyc, wb.stb, wb.we); end
      checks++; if (wb.sel !== 4'h0 || wb.data !== 32'h0) begin errors++; $display("[TB] FAIL reset_sel_data: got sel=%h data=%h expected 0 0", wb.sel, wb.data); end
      checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy_err: got %b %b expected 0 0", busy, err); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (gnt !== 4'h0 || wb.cyc !== 1'b0) begin errors++; $display("[TB] FAIL idle_noreq: got gnt=%h cyc=%b expected 0 0", gnt, wb.cyc); end
   endtask

   task automatic test_basic_write();
      int base;
      base = wr_count;
      led[7:0] = 8'hA5; req = 4'b0001;
      @(negedge clk);
      checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL first_gnt: got %b expected %b", gnt, 4'b0001); end
      checks++; if (wb.cyc !== 1'b1 || wb.stb !== 1'b1 || wb.we !== 1'b1) begin errors++; $display("[TB] FAIL first_ctl: got cyc=%b stb=%b we=%b expected 1 1 1", wb.cyc, wb.stb, wb.we); end
      checks++; if (wb.data !== 32'h0000_FFA5) begin errors++; $display("[TB] FAIL first_data: got %h expected %h", wb.data, 32'h0000_FFA5); end
      checks++; if (wb.sel !== 4'b0011) begin errors++; $display("[TB] FAIL first_sel: got %b expected %b", wb.sel, 4'b0011); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL first_busy: got %b expected 1", busy); end
      @(negedge clk);
      checks++; if (wb.stb !== 1'b0 || wb.cyc !== 1'b1) begin errors++; $display("[TB] FAIL ack_wait: got stb=%b cyc=%b expected 0 1", wb.stb, wb.cyc); end
      @(negedge clk);
      checks++; if (wb.cyc !== 1'b0 || led_pin !== 8'h00) begin errors++; $display("[TB] FAIL cyc_end: got cyc=%b leds=%h expected 0 00", wb.cyc, led_pin); end
      @(negedge clk);
      checks++; if (led_pin !== 8'hA5) begin errors++; $display("[TB] FAIL led_latency: got %h expected %h", led_pin, 8'hA5); end
      repeat (30) @(negedge clk);
      checks++; if (gnt !== 4'b0001 || wr_count !== base + 1) begin errors++; $display("[TB] FAIL single_owner: got gnt=%b writes=%0d expected 0001 %0d", gnt, wr_count - base, 1); end
   endtask

   task automatic test_update();
      int base;
      base = wr_count;
      led[23:16] = 8'h99; upd = 4'b0100;
      @(negedge clk);
      upd = 4'b0000;
      repeat (5) @(negedge clk);
      checks++; if (wr_count !== base || wb.cyc !== 1'b0) begin errors++; $display("[TB] FAIL nonowner_upd: got writes=%0d cyc=%b expected 0 0", wr_count - base, wb.cyc); end
      led[7:0] = 8'h5A; upd = 4'b0001;
      @(negedge clk);
      upd = 4'b0000;
      checks++; if (wb.stb !== 1'b1 || wb.data !== 32'h0000_FF5A) begin errors++; $display("[TB] FAIL upd_write: got stb=%b data=%h expected 1 %h", wb.stb, wb.data, 32'h0000_FF5A); end
      @(negedge clk);
      led[7:0] = 8'h3C; upd = 4'b0001;
      @(negedge clk);
      upd = 4'b0000;
      @(negedge clk);
      checks++; if (wb.stb !== 1'b1 || wb.data !== 32'h0000_FF3C) begin errors++; $display("[TB] FAIL pend_write: got stb=%b data=%h expected 1 %h", wb.stb, wb.data, 32'h0000_FF3C); end
      repeat (10) @(negedge clk);
      checks++; if (wr_count !== base + 2) begin errors++; $display("[TB] FAIL upd_count: got %0d expected %0d", wr_count - base, 2); end
      checks++; if (last_wdata !== 32'h0000_FF3C || led_pin !== 8'h3C) begin errors++; $display("[TB] FAIL upd_final: got data=%h leds=%h expected %h 3c", last_wdata, led_pin, 32'h0000_FF3C); end
   endtask

   task automatic test_stall();
      int base;
      base = wr_count;
      led[7:0] = 8'h77; upd = 4'b0001; wb.stall = 1'b1;
      @(negedge clk);
      upd = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         checks++; if (wb.stb !== 1'b1 || wb.data !== 32'h0000_FF77) begin errors++; $display("[TB] FAIL stall_hold%0d: got stb=%b data=%h expected 1 %h", i, wb.stb, wb.data, 32'h0000_FF77); end
         if (i == 2) wb.stall = 1'b0;
         @(negedge clk);
      end
      checks++; if (wb.stb !== 1'b0 || wb.cyc !== 1'b1) begin errors++; $display("[TB] FAIL stall_accept: got stb=%b cyc=%b expected 0 1", wb.stb, wb.cyc); end
      repeat (5) @(negedge clk);
      checks++; if (wr_count !== base + 1 || led_pin !== 8'h77) begin errors++; $display("[TB] FAIL stall_once: got writes=%0d leds=%h expected 1 77", wr_count - base, led_pin); end
   endtask

   task automatic test_release();
      int base, th;
      base = wr_count; th = twohot_cnt;
      led[15:8] = 8'h81; req = 4'b0010;
      @(negedge clk);
      checks++; if (gnt !== 4'b0010) begin errors++; $display("[TB] FAIL handover_gnt: got %b expected %b", gnt, 4'b0010); end
      repeat (3) @(negedge clk);
      req = 4'b0000;
      repeat (13) @(negedge clk);
      checks++; if (gnt !== 4'b0010) begin errors++; $display("[TB] FAIL hold_retained: got %b expected %b", gnt, 4'b0010); end
      @(negedge clk);
      checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin errors++; $display("[TB] FAIL release_idle: got gnt=%b busy=%b expected 0000 0", gnt, busy); end
      repeat (5) @(negedge clk);
      checks++; if (wr_count !== base + 1 || led_pin !== 8'h81 || wb.cyc !== 1'b0) begin errors++; $display("[TB] FAIL release_nowrite: got writes=%0d leds=%h cyc=%b expected 1 81 0", wr_count - base, led_pin, wb.cyc); end
      checks++; if (twohot_cnt !== th) begin errors++; $display("[TB] FAIL handover_twohot: got %0d expected 0", twohot_cnt - th); end
   endtask

   task automatic test_rotation();
      int th;
      th = twohot_cnt;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      led[7:0] = 8'h11; led[23:16] = 8'h22; req = 4'b0101;
      @(negedge clk);
      checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL rot_first: got %b expected %b", gnt, 4'b0001); end
      repeat (16) @(negedge clk);
      checks++; if (gnt !== 4'b0001) begin errors++; $display("[TB] FAIL rot_hold0: got %b expected %b", gnt, 4'b0001); end
      @(negedge clk);
      checks++; if (gnt !== 4'b0100 || wb.data !== 32'h0000_FF22) begin errors++; $display("[TB] FAIL rot_pre2: got gnt=%b data=%h expected 0100 %h", gnt, wb.data, 32'h0000_FF22); end
      repeat (16) @(negedge clk);
      checks++; if (gnt !== 4'b0100 || last_wdata !== 32'h0000_FF22) begin errors++; $display("[TB] FAIL rot_hold2: got gnt=%b data=%h expected 0100 %h", gnt, last_wdata, 32'h0000_FF22); end
      @(negedge clk);
      checks++; if (gnt !== 4'b0001 || wb.stb !== 1'b1) begin errors++; $display("[TB] FAIL rot_back0: got gnt=%b stb=%b expected 0001 1", gnt, wb.stb); end
      checks++; if (twohot_cnt !== th) begin errors++; $display("[TB] FAIL rot_twohot: got %0d expected 0", twohot_cnt - th); end
   endtask

   task automatic test_reset_mid_write();
      wb.stall = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (wb.cyc !== 1'b0 || wb.stb !== 1'b0 || gnt !== 4'h0) begin errors++; $display("[TB] FAIL async_abort: got cyc=%b stb=%b gnt=%b expected 0 0 0000", wb.cyc, wb.stb, gnt); end
      @(negedge clk);
      rst_n = 1'b1; wb.stall = 1'b0; req = 4'b0000;
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int base, ebase, n;
      base = wr_count; ebase = err_cnt; n = 0;
      led[7:0] = 8'h42; req = 4'b0001; ack_enable = 1'b0;
      @(negedge clk);
`ifdef SPIO_LEDARB_TIMEOUT_EN
      while (wb.cyc && n < 40) begin
         n++;
         @(negedge clk);
      end
      checks++; if (n !== 15) begin errors++; $display("[TB] FAIL wd_cycles: got %0d expected %0d", n, 15); end
      checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL wd_err: got %b expected 1", err); end
      ack_enable = 1'b1;
      @(negedge clk);
      checks++; if (err !== 1'b0 || wb.stb !== 1'b1 || wb.data !== 32'h0000_FF42) begin errors++; $display("[TB] FAIL wd_retry: got err=%b stb=%b data=%h expected 0 1 %h", err, wb.stb, wb.data, 32'h0000_FF42); end
      repeat (5) @(negedge clk);
      checks++; if (err_cnt - ebase !== 1 || wr_count - base !== 2 || wb.cyc !== 1'b0) begin errors++; $display("[TB] FAIL wd_summary: got errs=%0d writes=%0d cyc=%b expected 1 2 0", err_cnt - ebase, wr_count - base, wb.cyc); end
`else
      repeat (20) @(negedge clk);
      checks++; if (wb.cyc !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL no_wd_wait: got cyc=%b busy=%b expected 1 1", wb.cyc, busy); end
      checks++; if (err_cnt !== ebase || wr_count - base !== 1) begin errors++; $display("[TB] FAIL no_wd_err: got errs=%0d writes=%0d expected 0 1", err_cnt - ebase, wr_count - base); end
      ack_enable = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
`endif
   endtask

   initial begin
      rst_n = 1'b0; req = '0; upd = '0; led = '0; wb.stall = 1'b0; ack_enable = 1'b1;
      test_reset();
      test_basic_write();
      test_update();
      test_stall();
      test_release();
      test_rotation();
      test_reset_mid_write();
      test_timeout();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
